// File: rtl/sobel_frame_capture.sv
// Frame sink for the sobel pipeline: stores one cropped frame of valid-qualified pixels
// into on-chip RAM, tracks row/column, flags completion/overflow and serves readback.
module sobel_frame_capture #(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned HEIGHT  = 512,
  parameter int unsigned R_GAUSS = 2,
  parameter int unsigned R_SOBEL = 1,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [7:0]        in_pix,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] cur_row,
  output logic [ADDR_W-1:0] cur_col
);

  localparam int unsigned BORDER = 2 * (R_GAUSS + R_SOBEL);
  localparam int unsigned OUT_W  = WIDTH - BORDER;
  localparam int unsigned OUT_H  = HEIGHT - BORDER;
  localparam int unsigned NPIX   = OUT_W * OUT_H;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] cur_row_q, cur_row_d;
  logic [ADDR_W-1:0] cur_col_q, cur_col_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              wr_en_c;

  logic [7:0] mem [DEPTH];

  // Next-state, counter and flag logic; arm overrides everything including in_valid.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    wr_en_c      = 1'b0;
    if (arm) begin
      state_d      = S_CAPTURE;
      wr_addr_d    = '0;
      cur_row_d    = '0;
      cur_col_d    = '0;
      busy_d       = 1'b1;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (in_valid) begin
            wr_en_c   = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (cur_col_q == ADDR_W'(OUT_W - 1)) begin
              cur_col_d = '0;
              cur_row_d = cur_row_q + ADDR_W'(1);
            end else begin
              cur_col_d = cur_col_q + ADDR_W'(1);
            end
            if (wr_addr_q == ADDR_W'(NPIX - 1)) begin
              state_d      = S_DONE;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (in_valid) overflow_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Readback only while a complete frame is held; out-of-frame addresses return zero.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (rd_en && (state_q == S_DONE)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = (32'(rd_addr) < NPIX) ? mem[rd_addr] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Frame RAM is never reset so a stored frame survives everything but overwrite.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_q] <= in_pix;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Directed bench for sobel_frame_capture with a 6x4 output frame (24 pixels).
module tb_sobel_frame_capture;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic          in_valid;
  logic [7:0]    in_pix;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [AW-1:0] cur_row;
  logic [AW-1:0] cur_col;

  int total = 0;
  int bad   = 0;

  sobel_frame_capture #(
    .WIDTH(12), .HEIGHT(10), .R_GAUSS(2), .R_SOBEL(1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .in_valid(in_valid), .in_pix(in_pix),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(string tag, int b, int f, int o, int r, int c);
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(f));
    chk({tag, ".overflow"},   32'(overflow),   32'(o));
    chk({tag, ".cur_row"},    32'(cur_row),    32'(r));
    chk({tag, ".cur_col"},    32'(cur_col),    32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] p);
    in_valid = 1'b1;
    in_pix   = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Leaves rd_en high so consecutive calls form back-to-back reads.
  task automatic rd(string tag, logic [AW-1:0] a, logic [7:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"},  32'(rd_data),  32'(exp));
  endtask

  task automatic rd_stop(string tag);
    rd_en = 1'b0;
    tick();
    chk({tag, ".rd_valid_low"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic full_frame(string tag, logic [7:0] base);
    for (int i = 0; i < 24; i++) begin
      chk({tag, ".busy_pre"}, 32'(busy), 32'd1);
      push(base + 8'(i));
      if (i < 23) chk_st({tag, ".px"}, 1, 0, 0, (i + 1) / 6, (i + 1) % 6);
      else        chk_st({tag, ".end"}, 0, 1, 0, 4, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; in_valid = 1'b0; in_pix = 8'h00;
    rd_en = 1'b0; rd_addr = '0;
    #12;
    chk_st("reset", 0, 0, 0, 0, 0);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.rd_data",  32'(rd_data),  32'd0);
    rst_n = 1'b1;
    tick();

    // IDLE: reads ignored, pixels dropped without flags
    rd_en = 1'b1; rd_addr = 5'd3;
    tick();
    rd_en = 1'b0;
    chk("idle_rd.rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_rd.rd_data",  32'(rd_data),  32'd0);
    push(8'h55);
    chk_st("idle_px", 0, 0, 0, 0, 0);

    // 1: continuous frame, then back-to-back readback
    arm_pulse();
    chk_st("t1.arm", 1, 0, 0, 0, 0);
    full_frame("t1", 8'h00);
    for (int i = 0; i < 24; i++) rd("t1.rd", AW'(i), 8'(i));
    rd_stop("t1");

    // 2: same data with random gaps
    arm_pulse();
    chk_st("t2.arm", 1, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk_st("t2.gap", 1, 0, 0, i / 6, i % 6);
      end
      push(8'(i));
      if (i < 23) chk_st("t2.px", 1, 0, 0, (i + 1) / 6, (i + 1) % 6);
      else        chk_st("t2.end", 0, 1, 0, 4, 0);
    end
    rd("t2.rd0", 5'd0, 8'h00);
    rd("t2.rd11", 5'd11, 8'h0B);
    rd("t2.rd23", 5'd23, 8'h17);
    rd_stop("t2");

    // 3: overflow in DONE, RAM untouched, arm clears flags
    push(8'hFF);
    chk_st("t3.ov1", 0, 1, 1, 4, 0);
    push(8'hFF);
    push(8'hFF);
    chk_st("t3.ov3", 0, 1, 1, 4, 0);
    rd("t3.rd23", 5'd23, 8'h17);
    rd("t3.rd0", 5'd0, 8'h00);
    rd("t3.rd23b", 5'd23, 8'h17);
    rd_stop("t3");
    arm_pulse();
    chk_st("t3.arm", 1, 0, 0, 0, 0);

    // 5a: read during CAPTURE is ignored and rd_data holds
    rd_en = 1'b1; rd_addr = 5'd5;
    tick();
    rd_en = 1'b0;
    chk("t5.cap.rd_valid", 32'(rd_valid), 32'd0);
    chk("t5.cap.rd_data",  32'(rd_data),  32'h17);

    // 4: restart after 10 pixels, arm beats a concurrent pixel
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
    chk_st("t4.px10", 1, 0, 0, 1, 4);
    arm_pulse();
    chk_st("t4.rearm", 1, 0, 0, 0, 0);
    arm = 1'b1; in_valid = 1'b1; in_pix = 8'hAA;
    tick();
    arm = 1'b0; in_valid = 1'b0;
    chk_st("t4.arm_px", 1, 0, 0, 0, 0);
    full_frame("t4", 8'h30);
    rd("t4.rd0", 5'd0, 8'h30);
    rd("t4.rd10", 5'd10, 8'h3A);
    rd("t4.rd23", 5'd23, 8'h47);

    // 5b: out-of-frame addresses read as zero with rd_valid
    rd("t5.rd24", 5'd24, 8'h00);
    rd("t5.rd31", 5'd31, 8'h00);
    rd_stop("t5");

    // 6: async reset mid-capture, then full recapture
    arm_pulse();
    for (int i = 0; i < 15; i++) push(8'hC0 + 8'(i));
    chk_st("t6.px15", 1, 0, 0, 2, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_st("t6.rst", 0, 0, 0, 0, 0);
    chk("t6.rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("t6.rst.rd_data",  32'(rd_data),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_st("t6.idle", 0, 0, 0, 0, 0);
    arm_pulse();
    chk_st("t6.arm", 1, 0, 0, 0, 0);
    full_frame("t6", 8'hC0);
    for (int i = 0; i < 24; i++) rd("t6.rd", AW'(i), 8'hC0 + 8'(i));
    rd_stop("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
